// File: rtl/trakball_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module  : trakball_quad_decoder
// Brief   : Multi-channel trakball decoder (clock/dir or 4x quadrature) with
//           sync, glitch filter, masked clear and flip-aware registered read.
// Revision: 1.0
// ============================================================================
module trakball_quad_decoder #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 4,
    parameter int MODE        = 0,
    parameter int SATURATE    = 0,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3,
    parameter int CH_AW       = 2
) (
    input  logic                      clk_cpu_4x,
    input  logic                      reset_cpu_n,
    input  logic                      clk_cpu,
    input  logic [NUM_CH-1:0]         enc_a,
    input  logic [NUM_CH-1:0]         enc_b,
    input  logic                      flip,
    input  logic                      clr_req,
    input  logic [NUM_CH-1:0]         clr_mask,
    input  logic [CH_AW-1:0]          rd_ch,
    output logic [7:0]                rd_data,
    output logic [NUM_CH*CNT_W-1:0]   cnt_o,
    output logic [NUM_CH-1:0]         dir_o
);

    localparam int c_nb    = 2 * NUM_CH;
    localparam int c_arm_n = SYNC_STAGES + FILT_LEN + 1;
    localparam int c_arm_w = $clog2(c_arm_n + 1);
    localparam int c_run_w = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'((1 << (CNT_W - 1)) - 1);
    localparam logic [CNT_W-1:0] c_cnt_min = CNT_W'(1 << (CNT_W - 1));

    logic [SYNC_STAGES-1:0][c_nb-1:0] sync_q, sync_d;
    logic [c_nb-1:0]                  filt_q, filt_d;
    logic [c_nb-1:0][c_run_w-1:0]     run_q, run_d;
    logic [c_arm_w-1:0]               arm_q, arm_d;
    logic [NUM_CH-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0]                dir_q, dir_d;
    logic [NUM_CH-1:0]                err_q, err_d;
    logic [7:0]                       rd_data_q, rd_data_d;

    logic [c_nb-1:0]  samp;
    logic             armed;
    logic             clr_fire;
    logic [CH_AW-1:0] phys;

    assign samp     = sync_q[SYNC_STAGES-1];
    assign armed    = (arm_q == c_arm_w'(c_arm_n));
    assign clr_fire = clr_req & clk_cpu;

    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = {enc_b, enc_a};
        for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_d[s] = sync_q[s-1];
        end
        arm_d = armed ? arm_q : arm_q + c_arm_w'(1);
    end

    // Until armed the filter simply follows the synchroniser, so an input
    // idling high out of reset never looks like an edge.
    always_comb begin
        filt_d = filt_q;
        run_d  = '0;
        for (int i = 0; i < c_nb; i++) begin
            if (!armed || FILT_LEN == 0) begin
                filt_d[i] = samp[i];
            end else if (samp[i] != filt_q[i]) begin
                if (run_q[i] == c_run_w'(FILT_LEN - 1)) begin
                    filt_d[i] = samp[i];
                end else begin
                    run_d[i] = run_q[i] + c_run_w'(1);
                end
            end
        end
    end

    always_comb begin
        logic ev, up, bad, a_o, b_o, a_n, b_n;
        cnt_d = cnt_q;
        dir_d = dir_q;
        err_d = err_q;
        for (int c = 0; c < NUM_CH; c++) begin
            a_o = filt_q[c];
            b_o = filt_q[NUM_CH+c];
            a_n = filt_d[c];
            b_n = filt_d[NUM_CH+c];
            ev  = 1'b0;
            up  = 1'b0;
            bad = 1'b0;
            if (armed) begin
                if (MODE == 0) begin
                    ev = a_n & ~a_o;
                    up = b_n;
                end else if ({a_n, b_n} != {a_o, b_o}) begin
                    if ((a_n != a_o) && (b_n != b_o)) begin
                        bad = 1'b1;
                    end else begin
                        // {A, A^B} turns the gray sequence into a 2-bit binary count
                        ev = 1'b1;
                        up = ({a_n, a_n ^ b_n} == ({a_o, a_o ^ b_o} + 2'd1));
                    end
                end
            end
            if (clr_fire && clr_mask[c]) begin
                cnt_d[c] = '0;
                err_d[c] = 1'b0;
            end else begin
                if (bad) err_d[c] = 1'b1;
                if (ev) begin
                    dir_d[c] = up;
                    if (up) begin
                        if (!(SATURATE != 0 && cnt_q[c] == c_cnt_max))
                            cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end else begin
                        if (!(SATURATE != 0 && cnt_q[c] == c_cnt_min))
                            cnt_d[c] = cnt_q[c] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        phys      = rd_ch ^ (flip ? CH_AW'(NUM_CH / 2) : '0);
        rd_data_d = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (32'(rd_ch) < NUM_CH && 32'(phys) == c) begin
                rd_data_d[7]         = dir_q[c];
                rd_data_d[6]         = err_q[c];
                rd_data_d[CNT_W-1:0] = cnt_q[c];
            end
        end
    end

    always_ff @(posedge clk_cpu_4x or negedge reset_cpu_n) begin
        if (!reset_cpu_n) begin
            sync_q    <= '0;
            filt_q    <= '0;
            run_q     <= '0;
            arm_q     <= '0;
            cnt_q     <= '0;
            dir_q     <= '0;
            err_q     <= '0;
            rd_data_q <= '0;
        end else begin
            sync_q    <= sync_d;
            filt_q    <= filt_d;
            run_q     <= run_d;
            arm_q     <= arm_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            err_q     <= err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign cnt_o   = cnt_q;
    assign dir_o   = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_trakball_quad_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_trakball_quad_decoder
// Brief   : Directed bench: clock/dir wrap decoder and quadrature saturating one.
// Revision: 1.0
// ============================================================================
module tb_trakball_quad_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_cpu, clr_req, flip;
    logic [3:0]  clr_mask;
    logic [3:0]  a0, b0, a1, b1;
    logic [2:0]  rd_ch0;
    logic [1:0]  rd_ch1;
    logic [7:0]  rd0, rd1;
    logic [15:0] cnt0, cnt1;
    logic [3:0]  dir0, dir1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trakball_quad_decoder #(
        .NUM_CH(4), .CNT_W(4), .MODE(0), .SATURATE(0),
        .SYNC_STAGES(2), .FILT_LEN(3), .CH_AW(3)
    ) u_dut0 (
        .clk_cpu_4x(clk), .reset_cpu_n(rst_n), .clk_cpu(clk_cpu),
        .enc_a(a0), .enc_b(b0), .flip(flip), .clr_req(clr_req),
        .clr_mask(clr_mask), .rd_ch(rd_ch0), .rd_data(rd0),
        .cnt_o(cnt0), .dir_o(dir0)
    );

    trakball_quad_decoder #(
        .NUM_CH(4), .CNT_W(4), .MODE(1), .SATURATE(1),
        .SYNC_STAGES(2), .FILT_LEN(3), .CH_AW(2)
    ) u_dut1 (
        .clk_cpu_4x(clk), .reset_cpu_n(rst_n), .clk_cpu(clk_cpu),
        .enc_a(a1), .enc_b(b1), .flip(1'b0), .clr_req(clr_req),
        .clr_mask(clr_mask), .rd_ch(rd_ch1), .rd_data(rd1),
        .cnt_o(cnt1), .dir_o(dir1)
    );

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse0(input logic [3:0] mask, input int n);
        repeat (n) begin
            a0 = a0 | mask;
            cycles(8);
            a0 = a0 & ~mask;
            cycles(8);
        end
    endtask

    task automatic step1(input logic [1:0] ab);
        a1[1] = ab[1];
        b1[1] = ab[0];
        cycles(8);
    endtask

    initial begin
        rst_n = 1'b0; clk_cpu = 1'b1; clr_req = 1'b0; flip = 1'b0; clr_mask = '0;
        a0 = 4'hF; b0 = '0; a1 = '0; b1 = '0; rd_ch0 = '0; rd_ch1 = 2'd1;
        cycles(3);
        check_value("reset_cnt0", 32'(cnt0), 32'h0);
        check_value("reset_rd0", 32'(rd0), 32'h0);
        check_value("reset_cnt1", 32'(cnt1), 32'h0);
        rst_n = 1'b1;
        cycles(20);
        check_value("arm_no_event_cnt", 32'(cnt0), 32'h0);
        check_value("arm_no_event_dir", 32'(dir0), 32'h0);
        a0 = '0;
        cycles(10);

        // quadrature, saturating: 12 forward steps clamp at +7
        repeat (3) begin
            step1(2'b01); step1(2'b11); step1(2'b10); step1(2'b00);
        end
        check_value("quad_sat_cnt", 32'(cnt1[7:4]), 32'h7);
        check_value("quad_dir_up", 32'(dir1[1]), 32'h1);
        step1(2'b11);
        cycles(2);
        check_value("quad_err_rd", 32'(rd1), 32'hC7);
        step1(2'b01);
        check_value("quad_rev_cnt", 32'(cnt1[7:4]), 32'h6);
        check_value("quad_rev_dir", 32'(dir1[1]), 32'h0);
        clr_mask = 4'b0010; clk_cpu = 1'b0; clr_req = 1'b1;
        cycles(1);
        clr_req = 1'b0; clk_cpu = 1'b1;
        cycles(2);
        check_value("clr_needs_clk_cpu", 32'(rd1), 32'h46);
        clr_req = 1'b1;
        cycles(1);
        clr_req = 1'b0;
        cycles(2);
        check_value("clr_quad_rd", 32'(rd1), 32'h00);

        // clock/direction counting
        b0 = 4'b0001;
        cycles(8);
        pulse0(4'b0001, 5);
        check_value("cd_up_cnt", 32'(cnt0[3:0]), 32'h5);
        check_value("cd_up_dir", 32'(dir0[0]), 32'h1);
        b0 = 4'b0000;
        cycles(8);
        pulse0(4'b0001, 7);
        check_value("cd_down_cnt", 32'(cnt0[3:0]), 32'hE);
        check_value("cd_down_dir", 32'(dir0[0]), 32'h0);

        // glitch filter on ch2
        b0 = 4'b0100;
        cycles(8);
        a0[2] = 1'b1; cycles(2); a0[2] = 1'b0;
        cycles(10);
        check_value("glitch2_rejected", 32'(cnt0[11:8]), 32'h0);
        a0[2] = 1'b1; cycles(3); a0[2] = 1'b0;
        cycles(10);
        check_value("pulse3_accepted", 32'(cnt0[11:8]), 32'h1);

        // clear colliding with events on ch0 (masked) and ch3 (unmasked)
        b0 = 4'b1101;
        cycles(8);
        a0 = a0 | 4'b1001;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr_mask = 4'b0001; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        check_value("coll_ch0_cleared", 32'(cnt0[3:0]), 32'h0);
        check_value("coll_ch3_counted", 32'(cnt0[15:12]), 32'h1);
        check_value("coll_ch0_dir_kept", 32'(dir0[0]), 32'h0);
        check_value("coll_ch3_dir", 32'(dir0[3]), 32'h1);
        a0 = a0 & ~4'b1001;
        cycles(10);

        // flip-aware read mux
        pulse0(4'b0001, 3);
        pulse0(4'b0100, 4);
        check_value("flip_setup_cnt", 32'(cnt0), 32'h1503);
        cycles(2);
        check_value("rd_noflip_ch0", 32'(rd0), 32'h83);
        flip = 1'b1;
        cycles(1);
        check_value("rd_flip_ch0", 32'(rd0), 32'h85);
        rd_ch0 = 3'd1;
        cycles(1);
        check_value("rd_flip_ch1", 32'(rd0), 32'h81);
        rd_ch0 = 3'd4;
        cycles(1);
        check_value("rd_out_of_range", 32'(rd0), 32'h00);
        flip = 1'b0; rd_ch0 = 3'd0;

        // wrap at +max
        b0 = 4'b0010;
        cycles(8);
        pulse0(4'b0010, 8);
        check_value("wrap_cnt", 32'(cnt0[7:4]), 32'h8);
        check_value("wrap_dir", 32'(dir0[1]), 32'h1);

        // asynchronous reset mid-operation, then re-arm
        #2 rst_n = 1'b0;
        #1;
        check_value("midrst_cnt0", 32'(cnt0), 32'h0);
        check_value("midrst_dir0", 32'(dir0), 32'h0);
        check_value("midrst_cnt1", 32'(cnt1), 32'h0);
        cycles(2);
        a0 = 4'hF; b0 = 4'b0001;
        rst_n = 1'b1;
        cycles(20);
        check_value("rearm_no_event", 32'(cnt0), 32'h0);
        a0 = '0;
        cycles(10);
        pulse0(4'b0001, 1);
        check_value("post_rearm_cnt", 32'(cnt0[3:0]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
